// File: rtl/nv_dw_lsd_restore_pkg.sv
// nv_dw_lsd_restore_pkg
//    Shared definitions for the leading-sign-detect restore datapath:
//    - enc_width_f : width of the sign-bit count for a given data width,
//                    identical to the normalizer's count encoding.
//    - LO_BITS     : number of shift-count bits resolved in the first stage.
//    - sra_mask    : arithmetic right shift by (shift & mask) on a
//                    sign-extended operand of SRA_MAX_W bits. Callers sign
//                    extend into SRA_MAX_W and truncate the result back, so one
//                    function serves every data width.
package nv_dw_lsd_restore_pkg;

   localparam int LO_BITS   = 2;
   localparam int SRA_MAX_W = 256;

   function automatic int enc_width_f(input int w);
      if (w <= 2)        return 1;
      else if (w <= 4)   return 2;
      else if (w <= 8)   return 3;
      else if (w <= 16)  return 4;
      else if (w <= 32)  return 5;
      else if (w <= 64)  return 6;
      else if (w <= 128) return 7;
      else               return 8;
   endfunction

   function automatic logic signed [SRA_MAX_W-1:0] sra_mask(
      input logic signed [SRA_MAX_W-1:0] d,
      input logic        [7:0]           sh,
      input logic        [7:0]           mask
   );
      return d >>> (sh & mask);
   endfunction

endpackage

// File: rtl/nv_dw_sra_stage.sv
// nv_dw_sra_stage
//    One registered arithmetic-right-shift stage with its own valid/ready
//    register slice. Only the shift-count bits selected by 'mask' are applied
//    here; the remaining bits are expected to be carried to a later stage in
//    the side bus, which is registered alongside the data untouched.
//
// Ports:
//    clk, rstn           clock, asynchronous active-low reset
//    in_vld / in_rdy     upstream handshake
//    in_data             value to shift (two's complement)
//    in_sh               shift count (only bits in 'mask' are used)
//    in_side             side information registered with the data
//    out_vld / out_rdy   downstream handshake
//    out_data, out_side  registered results
module nv_dw_sra_stage
   import nv_dw_lsd_restore_pkg::*;
#(
   parameter int                    width      = 8,
   parameter int                    sh_width   = 3,
   parameter int                    side_width = 1,
   parameter logic [sh_width-1:0]   mask       = '1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [width-1:0]      in_data,
   input  logic [sh_width-1:0]   in_sh,
   input  logic [side_width-1:0] in_side,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [width-1:0]      out_data,
   output logic [side_width-1:0] out_side
);

   logic                  vld_p0;
   logic [width-1:0]      data_p0;
   logic [side_width-1:0] side_p0;

   // The slice can take a new item whenever it is empty or its item leaves now.
   assign in_rdy = !vld_p0 || out_rdy;

   // ---- register stage ----
   // Data and side only load on a real transfer, so a bubble or a stall keeps
   // the last value on the outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         side_p0 <= '0;
      end else if (in_rdy) begin
         vld_p0 <= in_vld;
         if (in_vld) begin
            // Replicating the MSB then truncating gives the sign extension
            // into the helper's fixed width for any 'width'.
            data_p0 <= width'(sra_mask(
                          SRA_MAX_W'({{SRA_MAX_W{in_data[width-1]}}, in_data}),
                          8'(in_sh), 8'(mask)));
            side_p0 <= in_side;
         end
      end
   end

   assign out_vld  = vld_p0;
   assign out_data = data_p0;
   assign out_side = side_p0;

endmodule

// File: rtl/nv_dw_lsd_restore.sv
// nv_dw_lsd_restore
//    Inverse of the leading-sign-detect normalizer: given a left-normalized
//    value and its sign-bit count, rebuilds the original two's-complement value
//    as out = in_data >>> enc. The shift is split across two valid/ready
//    register stages: stage 1 applies the low LO_BITS of the count, stage 2 the
//    remaining high bits. Counts above a_width-1 are clamped and flagged.
//
// Ports:
//    nvdla_core_clk, nvdla_core_rstn   clock, asynchronous active-low reset
//    in_pvld / in_prdy                 input handshake
//    in_data   [a_width-1:0]           normalized value
//    in_enc    [enc_width-1:0]         sign-bit count from the normalizer
//    out_pvld / out_prdy               output handshake
//    out_data  [a_width-1:0]           restored value
//    out_ovf                           in_enc was above a_width-1 (clamped)
module nv_dw_lsd_restore
   import nv_dw_lsd_restore_pkg::*;
#(
   parameter int a_width = 8
) (
   input  logic                                nvdla_core_clk,
   input  logic                                nvdla_core_rstn,
   input  logic                                in_pvld,
   output logic                                in_prdy,
   input  logic [a_width-1:0]                  in_data,
   input  logic [enc_width_f(a_width)-1:0]     in_enc,
   output logic                                out_pvld,
   input  logic                                out_prdy,
   output logic [a_width-1:0]                  out_data,
   output logic                                out_ovf
);

   localparam int enc_width = enc_width_f(a_width);
   localparam logic [enc_width-1:0] LO_MASK = enc_width'((1 << LO_BITS) - 1);
   localparam logic [enc_width-1:0] HI_MASK = ~LO_MASK;

   logic                 ovf_p0;
   logic [enc_width-1:0] sh_p0;
   logic [enc_width:0]   side_p0;

   logic                 s1_vld;
   logic                 s1_rdy;
   logic [a_width-1:0]   s1_data;
   logic [enc_width:0]   s1_side;

   // ---- stage 0: clamp at acceptance ----
   // The widened compare keeps the test meaningful even where in_enc cannot
   // exceed a_width-1 (power-of-two widths).
   always_comb begin
      ovf_p0  = (int'(in_enc) > (a_width - 1));
      sh_p0   = ovf_p0 ? enc_width'(a_width - 1) : in_enc;
      side_p0 = {sh_p0 & HI_MASK, ovf_p0};
   end

   // ---- stage 1: low shift bits; high bits and ovf ride along ----
   nv_dw_sra_stage #(
      .width      (a_width),
      .sh_width   (enc_width),
      .side_width (enc_width + 1),
      .mask       (LO_MASK)
   ) u_s1 (
      .clk      (nvdla_core_clk),
      .rstn     (nvdla_core_rstn),
      .in_vld   (in_pvld),
      .in_rdy   (in_prdy),
      .in_data  (in_data),
      .in_sh    (sh_p0),
      .in_side  (side_p0),
      .out_vld  (s1_vld),
      .out_rdy  (s1_rdy),
      .out_data (s1_data),
      .out_side (s1_side)
   );

   // ---- stage 2: high shift bits ----
   nv_dw_sra_stage #(
      .width      (a_width),
      .sh_width   (enc_width),
      .side_width (1),
      .mask       (HI_MASK)
   ) u_s2 (
      .clk      (nvdla_core_clk),
      .rstn     (nvdla_core_rstn),
      .in_vld   (s1_vld),
      .in_rdy   (s1_rdy),
      .in_data  (s1_data),
      .in_sh    (s1_side[enc_width:1]),
      .in_side  (s1_side[0]),
      .out_vld  (out_pvld),
      .out_rdy  (out_prdy),
      .out_data (out_data),
      .out_side (out_ovf)
   );

endmodule

// File: tb/tb_nv_dw_lsd_restore.sv
// Testbench for nv_dw_lsd_restore: three instances (a_width 8, 12, 16) share
// clock and reset. Each accepted input pushes its expected {ovf, data} onto a
// per-instance scoreboard queue; each emitted output is compared with the
// queue head.
module tb_nv_dw_lsd_restore;

   typedef struct {
      logic [16:0] v;
      int          cyc;
   } item_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  ipvld;
   logic [2:0]  oprdy;
   wire  [2:0]  iprdy;
   wire  [2:0]  opvld;
   wire  [2:0]  oovf;

   logic [7:0]  d8;
   logic [2:0]  e8;
   logic [11:0] d12;
   logic [3:0]  e12;
   logic [15:0] d16;
   logic [3:0]  e16;
   wire  [7:0]  od8;
   wire  [11:0] od12;
   wire  [15:0] od16;

   item_t       sbq [3][$];
   logic [16:0] cur_exp [3];
   logic [2:0]  acc;
   logic [2:0]  pend;
   int          cyc;
   bit          lat_chk;
   int          n_cmp;
   int          n_bad;

   always #5 clk = ~clk;

   nv_dw_lsd_restore #(.a_width(8)) u_dut8 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .in_pvld(ipvld[0]), .in_prdy(iprdy[0]), .in_data(d8), .in_enc(e8),
      .out_pvld(opvld[0]), .out_prdy(oprdy[0]), .out_data(od8), .out_ovf(oovf[0]));

   nv_dw_lsd_restore #(.a_width(12)) u_dut12 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .in_pvld(ipvld[1]), .in_prdy(iprdy[1]), .in_data(d12), .in_enc(e12),
      .out_pvld(opvld[1]), .out_prdy(oprdy[1]), .out_data(od12), .out_ovf(oovf[1]));

   nv_dw_lsd_restore #(.a_width(16)) u_dut16 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .in_pvld(ipvld[2]), .in_prdy(iprdy[2]), .in_data(d16), .in_enc(e16),
      .out_pvld(opvld[2]), .out_prdy(oprdy[2]), .out_data(od16), .out_ovf(oovf[2]));

   function automatic int width_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 12 : 16;
   endfunction

   function automatic logic [16:0] get_out(input int k);
      case (k)
         0:       return {oovf[0], 8'h00, od8};
         1:       return {oovf[1], 4'h0, od12};
         default: return {oovf[2], od16};
      endcase
   endfunction

   // Golden normalizer count: sign-bit copies below the MSB.
   function automatic int norm_cnt(input logic [15:0] x, input int w);
      int e;
      e = 0;
      for (int i = w - 2; i >= 0; i--) begin
         if (x[i] == x[w-1]) e++;
         else break;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int k, input logic [15:0] d, input logic [3:0] e,
                         input logic [16:0] ex);
      case (k)
         0:       begin d8  = d[7:0];  e8  = e[2:0]; end
         1:       begin d12 = d[11:0]; e12 = e;      end
         default: begin d16 = d;       e16 = e;      end
      endcase
      cur_exp[k] = ex;
   endtask

   // One clock: settle, record transfers that the next posedge will perform,
   // then move to the following negedge.
   task automatic step();
      item_t it;
      #1;
      for (int k = 0; k < 3; k++) begin
         acc[k] = ipvld[k] & iprdy[k];
         if (acc[k]) begin
            it.v   = cur_exp[k];
            it.cyc = cyc;
            sbq[k].push_back(it);
         end
         if (opvld[k]) begin
            if (sbq[k].size() == 0) begin
               chk($sformatf("spurious_out%0d", k), {31'b0, opvld[k]}, 32'd0);
            end else begin
               it = sbq[k][0];
               chk($sformatf("out%0d", k), {15'b0, get_out(k)}, {15'b0, it.v});
               if (oprdy[k]) begin
                  void'(sbq[k].pop_front());
                  if (lat_chk) chk($sformatf("latency%0d", k), cyc - it.cyc, 32'd2);
               end
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic send(input int k, input logic [15:0] d, input logic [3:0] e,
                       input logic [16:0] ex);
      int n;
      set_in(k, d, e, ex);
      ipvld[k] = 1'b1;
      acc[k]   = 1'b0;
      n = 0;
      while (!acc[k] && n < 20) begin
         step();
         n++;
      end
      if (!acc[k]) chk($sformatf("accept_timeout%0d", k), {31'b0, acc[k]}, 32'd1);
      ipvld[k] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
         step();
         n++;
      end
      chk("drain_left", sbq[0].size() + sbq[1].size() + sbq[2].size(), 32'd0);
   endtask

   initial begin
      logic [15:0] x;
      logic [15:0] msk;
      int          w;
      int          e;

      n_cmp = 0; n_bad = 0; cyc = 0; lat_chk = 0;
      acc = '0; pend = '0; ipvld = '0; oprdy = '0;
      d8 = '0; e8 = '0; d12 = '0; e12 = '0; d16 = '0; e16 = '0;
      for (int k = 0; k < 3; k++) cur_exp[k] = '0;
      rstn = 1'b0;

      // Reset state
      #3;
      chk("rst_pvld", {29'b0, opvld}, 32'd0);
      chk("rst_ovf", {29'b0, oovf}, 32'd0);
      chk("rst_data8", {24'b0, od8}, 32'd0);
      chk("rst_data12", {20'b0, od12}, 32'd0);
      chk("rst_data16", {16'b0, od16}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Single item, two-cycle latency
      oprdy   = 3'b111;
      lat_chk = 1;
      send(0, 16'h00A0, 4'd4, {1'b0, 16'h00FA});
      drain();

      // Back-to-back items
      send(0, 16'h0050, 4'd4, {1'b0, 16'h0005});
      send(0, 16'h0080, 4'd7, {1'b0, 16'h00FF});
      send(0, 16'h0000, 4'd7, {1'b0, 16'h0000});
      send(0, 16'h007F, 4'd0, {1'b0, 16'h007F});
      drain();
      lat_chk = 0;

      // Backpressure: two accepts fill the pipe, third waits
      oprdy[0] = 1'b0;
      send(0, 16'h0040, 4'd2, {1'b0, 16'h0010});
      send(0, 16'h00C0, 4'd1, {1'b0, 16'h00E0});
      set_in(0, 16'h0033, 4'd0, {1'b0, 16'h0033});
      ipvld[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_in_prdy", {31'b0, iprdy[0]}, 32'd0);
         chk("bp_out_pvld", {31'b0, opvld[0]}, 32'd1);
         step();
      end
      oprdy[0] = 1'b1;
      send(0, 16'h0033, 4'd0, {1'b0, 16'h0033});
      #1;
      chk("bp_rel_pvld1", {31'b0, opvld[0]}, 32'd1);
      step();
      #1;
      chk("bp_rel_pvld2", {31'b0, opvld[0]}, 32'd1);
      step();
      drain();

      // Clamp on the 12-bit instance
      send(1, 16'h0800, 4'd15, {1'b1, 16'h0FFF});
      send(1, 16'h0400, 4'd10, {1'b0, 16'h0001});
      drain();

      // Reset while two items are in flight
      oprdy[0] = 1'b0;
      send(0, 16'h007F, 4'd1, {1'b0, 16'h003F});
      send(0, 16'h0080, 4'd1, {1'b0, 16'h00C0});
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_pvld", {31'b0, opvld[0]}, 32'd0);
      chk("midrst_data", {24'b0, od8}, 32'd0);
      chk("midrst_ovf", {31'b0, oovf[0]}, 32'd0);
      for (int k = 0; k < 3; k++) sbq[k].delete();
      @(negedge clk);
      rstn = 1'b1;
      oprdy[0] = 1'b1;
      @(negedge clk);
      send(0, 16'h0090, 4'd2, {1'b0, 16'h00E4});
      drain();
      for (int i = 0; i < 4; i++) step();

      // Random round trip on all three widths
      for (int s = 0; s < 400; s++) begin
         for (int k = 0; k < 3; k++) begin
            if (acc[k] || !pend[k]) begin
               w   = width_of(k);
               msk = 16'((32'd1 << w) - 1);
               if ($urandom_range(0, 3) == 0) begin
                  x = 16'($urandom_range(0, 15));
                  if ($urandom_range(0, 1) == 1) x = ~x;
               end else begin
                  x = 16'($urandom);
               end
               x = x & msk;
               if (x[w-1]) x = x | ~msk;
               e = norm_cnt(x, w);
               set_in(k, (x << e) & msk, 4'(e), {1'b0, x & msk});
               pend[k] = 1'b1;
            end
            ipvld[k] = ($urandom_range(0, 3) != 0);
            oprdy[k] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      ipvld = '0;
      oprdy = 3'b111;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nv_dw_lsd_restore.md
Name: nv_dw_lsd_restore

Overview:
- Inverse of the leading-sign-detect normalizer.
- Takes a left-normalized value and its sign-bit count, and rebuilds the original two's-complement value by arithmetic right shift (out = in_data >>> enc).
- Two-stage valid/ready pipeline. Sits after normalized-datapath arithmetic, before values return to the integer domain.

Parameters:
- a_width, 8: data width in bits.
- enc_width, derived localparam: 1 for a_width<=2; 2 for <=4; 3 for <=8; 4 for <=16; 5 for <=32; 6 for <=64; 7 for <=128; 8 otherwise. Same encoding as the sign-count output of the normalizer.
- LO_BITS, localparam, value 2: number of shift-count bits applied in stage 1.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- in_pvld  in  1  input valid.
- in_prdy  out  1  input ready.
- in_data  in  a_width  normalized value.
- in_enc  in  enc_width  sign-bit count produced by the normalizer.
- out_pvld  out  1  output valid.
- out_prdy  in  1  output ready.
- out_data  out  a_width  restored value.
- out_ovf  out  1  in_enc exceeded a_width-1; the shift was clamped.

Behaviour:
- Reset: one clock, nvdla_core_clk. Reset is asynchronous, active-low, on nvdla_core_rstn. All state clears: s1/s2 valid=0, data=0, shift=0, ovf=0. Hence out_pvld=0, out_data=0, out_ovf=0.
- Reset asserted mid-operation: in-flight items are dropped. No partial output appears after release.
- Handshake: transfer occurs when pvld & prdy are both high in the same cycle.
  - in_prdy = !s1_vld | s1_rdy
  - s1_rdy = !s2_vld | out_prdy
  - These ready terms are combinational; no combinational path exists from in_pvld to out_pvld.
- Throughput and latency: one item per cycle. An accepted item appears on out_pvld two cycles later if out_prdy stays high.
- Stalls:
  - A stalled stage holds its data, shift and ovf bits stable while valid.
  - Out_data must not change while out_pvld=1 and out_prdy=0.
  - Item order is preserved. Nothing is dropped or duplicated.
- Clamp (computed at acceptance):
  - If in_enc > a_width-1: sh = a_width-1, ovf=1.
  - Otherwise: sh = in_enc, ovf=0.
- Stage 1:
  - Registers s1_data = in_data >>> sh[LO_BITS-1:0], arithmetic, MSB replicated.
  - Also registers s1_sh_hi = sh with its low LO_BITS cleared, and s1_ovf.
- Stage 2:
  - Registers s2_data = s1_data >>> s1_sh_hi, and s2_ovf = s1_ovf.
  - out_data = s2_data, out_ovf = s2_ovf.
- Width rules: all shifts are computed at a_width. No intermediate widening is visible at the outputs. Shift by 0 passes data unchanged.
- Simultaneous accept and emit: when s2 drains (out_prdy=1) and s1 holds an item, s1 advances into s2 in the same cycle. Stage 1 may accept a new input in that same cycle.
- Full pipeline: with both stages valid and out_prdy=0, in_prdy=0.
- Empty pipeline: out_pvld=0. out_data holds its last value.
- Bubbles: in_pvld=0 cycles create bubbles that propagate. A bubble never produces out_pvld.
- Round-trip property: for any x with normalizer count e, the normalized value is n = x<<e, and restore(n, e) = x.

Decomposition:
- Shared package (vlibs common defines):
  - the enc_width derivation function for a_width;
  - LO_BITS;
  - the arithmetic-right-shift-by-mask helper function.
- One sub-module is natural: nv_dw_sra_stage, a registered arithmetic right shifter.
  - Parameters: width, shift width, mask.
  - Includes the local valid/ready register slice.
  - Instantiated twice, with low-bit and high-bit masks.

Test Plan:
- a_width=8, in_data=8'hA0, in_enc=4, out_prdy=1 -> out_data=8'hFA, out_ovf=0, out_pvld exactly 2 cycles after acceptance.
- a_width=8, back-to-back inputs, out_prdy=1:
  - (8'h50, 4) -> 8'h05
  - (8'h80, 7) -> 8'hFF
  - (8'h00, 7) -> 8'h00
  - (8'h7F, 0) -> 8'h7F
  - Four outputs on consecutive cycles, in order.
- Backpressure: push 3 items, out_prdy=0 for 4 cycles -> in_prdy drops after 2 accepts and out_data stays stable. Release -> all 3 items emerge in order, 1 per cycle.
- a_width=12 (enc_width=4), in_data=12'h800, in_enc=15 -> clamp to 11: out_data=12'hFFF, out_ovf=1. Next item (12'h400, 10) -> out_data=12'h001, out_ovf=0.
- Reset mid-flight: assert nvdla_core_rstn=0 asynchronously with 2 items in the pipe -> out_pvld=0 and out_data=0 immediately. After release, only newly accepted items emerge.
- Random round-trip, a_width in {8,12,16}: drive x -> golden normalizer count e -> feed (x<<e, e) with random in_pvld/out_prdy -> every output equals x, with ovf=0.
